reg_share_arbiter: RTL and testbench
====================================

Name: reg_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from the team's resettable DFF cells.
- Up to N_REQ requesters compete for write access. The block grants one requester at a time, loads its data into the register, and acknowledges the write.
- An optional lock lets the owner hold the register for a bounded burst of consecutive writes.
- Sits between requester logic and the shared q/qn storage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register.
- MAX_HOLD, 4, maximum writes per tenure while lock is held (>=1).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- res  in  1  reset, asynchronous, active-low; low clears all state immediately.
- req  in  N_REQ  per-requester write request.
- lock  in  N_REQ  per-requester burst-hold request; qualified by req.
- wdata  in  N_REQ*WIDTH  write data; slice i = wdata[i*WIDTH +: WIDTH].
- gnt  out  N_REQ  registered one-hot grant.
- ack  out  N_REQ  registered one-cycle write acknowledge.
- q  out  WIDTH  shared register contents.
- qn  out  WIDTH  always ~q.
- busy  out  1  high while in GRANT.
- owner  out  clog2(N_REQ)  index of the current or last grantee.

Behaviour:
Reset (res low, async):
- state=IDLE; gnt=0; ack=0; busy=0; q=0; qn=all ones; owner=0; ptr=0; hold_cnt=0.
- Reset asserted mid-tenure aborts it: no ack is issued and q is cleared.

Arbitration function:
- Winner = first index i scanning ptr, ptr+1, ... modulo N_REQ with req[i]=1.
- On grant: owner<=i, gnt<=onehot(i), hold_cnt<=0.

FSM state IDLE:
- gnt=0.
- If any req at posedge: grant the winner and go to GRANT.
- Request-to-grant latency is 1 cycle.

FSM state GRANT (owner o):
- A write occurs at the posedge where gnt[o]&req[o]: q<=wdata slice o, and ack[o]=1 for exactly the following cycle. All other ack bits are 0.
- Stay condition, evaluated at the write edge: lock[o]&req[o] and hold_cnt<MAX_HOLD-1. Then keep gnt and increment hold_cnt.
- Release at the write edge otherwise: ptr<=o+1 mod N_REQ, then re-arbitrate immediately in the same edge.
  - If a winner exists, gnt moves to it. The winner may be o if o is the only requester.
  - If no requester, go to IDLE and drop gnt.
- If req[o]=0 at the edge: no write, no ack, q unchanged. Release as above.

Throughput and timing rules:
- Back-to-back tenures give one write per cycle with no idle cycle between owners.
- Requesters treat gnt[i]&req[i] at an edge as write accepted. Holding req high after the accepted write makes a new request.
- busy=1 exactly when state=GRANT.
- qn is combinational from q; it is never independently registered.
- Only q, gnt, ack, owner, ptr, hold_cnt and state are registers.

Boundary rules:
- lock without req is ignored.
- lock on a non-owner has no effect.
- ptr wraps from N_REQ-1 to 0.
- MAX_HOLD=1 makes lock have no effect.

Test Plan:
1. Reset: drive res=0 mid-run with q=3C -> q=00, qn=FF, gnt=0000, ack=0000, busy=0 immediately without a clock edge. Release res and hold req=0 -> outputs stay at reset values.
2. Single write: req=0001, wdata0=A5 from reset -> after edge 1 gnt=0001, busy=1; after edge 2 q=A5, qn=5A, ack=0001 for one cycle. Drop req in the ack cycle -> after edge 3 gnt=0000, busy=0.
3. Round robin: req=1111 held, lock=0, wdata slices 11/22/33/44 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; q follows 11,22,33,44 one cycle behind gnt; ack one-hot tracks the writer.
4. Lock burst: req=0011, lock=0001, MAX_HOLD=4 -> requester 0 gets 4 consecutive writes and 4 acks, then gnt=0010 and requester 1 writes next. After that, owner 0 wins again only via rotation.
5. Grant dropped: grant requester 2, then deassert req[2] before the next edge -> no ack, q unchanged. Rotation continues with ptr=3: pending req[3] wins next, otherwise IDLE.
6. Reset mid-burst: requester 1 locked, hold_cnt=2, assert res=0 -> gnt=0000, ack=0000, q=00. After release, a fresh req=0010 is granted with hold_cnt restarted: 4 writes allowed.

Source files
------------

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bundle for the shared-register arbiter: requests, lock,
// write data, and the grant/ack/storage view returned to the requesters.
interface reg_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qn;
  logic                   busy;
  logic [OW-1:0]          owner;

  modport master (output req, lock, wdata, input gnt, ack, q, qn, busy, owner);
  modport slave  (input req, lock, wdata, output gnt, ack, q, qn, busy, owner);
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register,
// with a bounded lock burst for the current owner.
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              res,
  reg_share_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                       state, state_nx;
  logic [N_REQ-1:0]             gnt, ack;
  logic [WIDTH-1:0]             q;
  logic [OW-1:0]                owner, ptr, nxt_o, base, win_idx;
  logic [HW-1:0]                hold_cnt;
  logic                         win_found, wr, stay, busy;
  logic [N_REQ-1:0][WIDTH-1:0]  wd;

  assign wd    = bus.wdata;
  assign nxt_o = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign wr    = (state == GRANT) && bus.req[owner];
  assign stay  = wr && bus.lock[owner] && (hold_cnt < HOLD_LAST);
  // On release the scan starts just past the owner, so a release and the
  // next grant happen on the same edge.
  assign base  = (state == GRANT) ? nxt_o : ptr;

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(base) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && bus.req[j[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|bus.req) state_nx = GRANT;
      GRANT:   if (!stay && !win_found) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == GRANT) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      gnt      <= '0;
      ack      <= '0;
      q        <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      ack <= '0;
      if (wr) begin
        ack[owner] <= 1'b1;
        q          <= wd[owner];
      end
      if (stay) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        if (state == GRANT) ptr <= nxt_o;
        gnt <= '0;
        if (win_found) begin
          owner        <= win_idx;
          gnt[win_idx] <= 1'b1;
          hold_cnt     <= '0;
        end
      end
    end
  end

  assign bus.gnt   = gnt;
  assign bus.ack   = ack;
  assign bus.q     = q;
  assign bus.qn    = ~q;
  assign bus.busy  = busy;
  assign bus.owner = owner;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: rule-level model compared every cycle,
// plus literal checks at the key points of each scenario.
module tb_reg_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MH  = 4;
  localparam int OWT = $clog2(N);

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .res(res), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the register, where the rotation resumes,
  // how many writes the current tenure has used.
  bit             m_busy;
  logic [OWT-1:0] m_owner, m_ptr;
  int             m_hold;
  logic [W-1:0]   m_q;
  logic [N-1:0]   m_ack;

  function automatic int pick(input int from, input logic [N-1:0] r);
    logic [OWT-1:0] ix;
    for (int k = 0; k < N; k++) begin
      ix = OWT'((from + k) % N);
      if (r[ix]) return int'(ix);
    end
    return -1;
  endfunction

  always @(posedge clk or negedge res) begin
    automatic bit wr;
    automatic int nxt, w;
    if (!res) begin
      m_busy  <= 1'b0;
      m_owner <= '0;
      m_ptr   <= '0;
      m_hold  <= 0;
      m_q     <= '0;
      m_ack   <= '0;
    end else begin
      wr  = m_busy && bus.req[m_owner];
      nxt = (int'(m_owner) + 1) % N;
      m_ack <= '0;
      if (wr) begin
        m_ack[m_owner] <= 1'b1;
        m_q <= bus.wdata[int'(m_owner)*W +: W];
      end
      if (wr && bus.lock[m_owner] && m_hold < MH - 1) begin
        m_hold <= m_hold + 1;
      end else begin
        w = pick(m_busy ? nxt : int'(m_ptr), bus.req);
        if (m_busy) m_ptr <= OWT'(nxt);
        m_busy <= (w >= 0);
        if (w >= 0) begin
          m_owner <= OWT'(w);
          m_hold  <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    automatic logic [N-1:0] eg;
    automatic logic [W-1:0] eqn;
    if (chk_en && res) begin
      eg = '0;
      if (m_busy) eg[m_owner] = 1'b1;
      eqn = ~m_q;
      check("gnt",   32'(bus.gnt),   32'(eg));
      check("ack",   32'(bus.ack),   32'(m_ack));
      check("q",     32'(bus.q),     32'(m_q));
      check("qn",    32'(bus.qn),    32'(eqn));
      check("busy",  32'(bus.busy),  32'(m_busy));
      check("owner", 32'(bus.owner), 32'(m_owner));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l);
    bus.req  = r;
    bus.lock = l;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, ".q"},    32'(bus.q),    32'h00);
    check({tag, ".qn"},   32'(bus.qn),   32'hFF);
    check({tag, ".gnt"},  32'(bus.gnt),  32'h0);
    check({tag, ".ack"},  32'(bus.ack),  32'h0);
    check({tag, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    bus.req = '0; bus.lock = '0; bus.wdata = '0;
    res = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    res = 1'b1; chk_en = 1'b1;
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk_reset_vals("idle");

    // single write from requester 0
    bus.wdata = 32'h000000A5;
    cyc(4'b0001, 4'b0000);
    check("sw.gnt1", 32'(bus.gnt), 32'h1);
    check("sw.busy1", 32'(bus.busy), 32'h1);
    cyc(4'b0001, 4'b0000);
    check("sw.q", 32'(bus.q), 32'hA5);
    check("sw.qn", 32'(bus.qn), 32'h5A);
    check("sw.ack", 32'(bus.ack), 32'h1);
    cyc(4'b0000, 4'b0000);
    check("sw.gnt3", 32'(bus.gnt), 32'h0);
    check("sw.busy3", 32'(bus.busy), 32'h0);
    check("sw.ack3", 32'(bus.ack), 32'h0);

    // async reset mid-tenure with q=3C
    bus.wdata = 32'h00003C00;
    cyc(4'b0010, 4'b0000);
    check("rs.gnt", 32'(bus.gnt), 32'h2);
    cyc(4'b0010, 4'b0000);
    check("rs.q", 32'(bus.q), 32'h3C);
    #2 res = 1'b0;
    #1 chk_reset_vals("async");
    check("async.owner", 32'(bus.owner), 32'h0);
    @(negedge clk);
    res = 1'b1;
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk_reset_vals("post");

    // round robin, all requesting
    bus.wdata = 32'h44332211;
    cyc(4'b1111, 4'b0000);
    check("rr.g0", 32'(bus.gnt), 32'h1);
    cyc(4'b1111, 4'b0000);
    check("rr.g1", 32'(bus.gnt), 32'h2); check("rr.q1", 32'(bus.q), 32'h11); check("rr.a1", 32'(bus.ack), 32'h1);
    cyc(4'b1111, 4'b0000);
    check("rr.g2", 32'(bus.gnt), 32'h4); check("rr.q2", 32'(bus.q), 32'h22); check("rr.a2", 32'(bus.ack), 32'h2);
    cyc(4'b1111, 4'b0000);
    check("rr.g3", 32'(bus.gnt), 32'h8); check("rr.q3", 32'(bus.q), 32'h33); check("rr.a3", 32'(bus.ack), 32'h4);
    cyc(4'b1111, 4'b0000);
    check("rr.wrap", 32'(bus.gnt), 32'h1); check("rr.q4", 32'(bus.q), 32'h44); check("rr.a4", 32'(bus.ack), 32'h8);
    cyc(4'b0000, 4'b0000);
    check("rr.idle", 32'(bus.busy), 32'h0); check("rr.noack", 32'(bus.ack), 32'h0);

    // lock burst: rotation sits at 1, so requester 1 writes once, then 0 bursts
    bus.wdata = 32'h0000B1A0;
    cyc(4'b0011, 4'b0001);
    check("lk.g1", 32'(bus.gnt), 32'h2);
    cyc(4'b0011, 4'b0001);
    check("lk.a1", 32'(bus.ack), 32'h2); check("lk.to0", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus.wdata[7:0] = 8'hA0 + 8'(i);
      cyc(4'b0011, 4'b0001);
      check("lk.burst.gnt", 32'(bus.gnt), 32'h1);
      check("lk.burst.ack", 32'(bus.ack), 32'h1);
      check("lk.burst.q", 32'(bus.q), 32'(8'hA0 + 8'(i)));
    end
    bus.wdata[7:0] = 8'hA3;
    cyc(4'b0011, 4'b0001);
    check("lk.4th.ack", 32'(bus.ack), 32'h1); check("lk.release", 32'(bus.gnt), 32'h2);
    check("lk.4th.q", 32'(bus.q), 32'hA3);
    cyc(4'b0011, 4'b0001);
    check("lk.b.ack", 32'(bus.ack), 32'h2); check("lk.rot0", 32'(bus.gnt), 32'h1);
    cyc(4'b0000, 4'b0001);
    check("lk.idle", 32'(bus.gnt), 32'h0);

    // grant dropped before write
    bus.wdata = 32'hDDCC0000;
    cyc(4'b0100, 4'b0000);
    check("gd.g2", 32'(bus.gnt), 32'h4);
    cyc(4'b1000, 4'b0000);
    check("gd.noack", 32'(bus.ack), 32'h0); check("gd.qkeep", 32'(bus.q), 32'hB1);
    check("gd.g3", 32'(bus.gnt), 32'h8);
    cyc(4'b1000, 4'b0000);
    check("gd.a3", 32'(bus.ack), 32'h8); check("gd.q3", 32'(bus.q), 32'hDD);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0100, 4'b0000);
    check("gd.g2b", 32'(bus.gnt), 32'h4);
    cyc(4'b0000, 4'b0000);
    check("gd.idle", 32'(bus.busy), 32'h0); check("gd.noack2", 32'(bus.ack), 32'h0);

    // reset mid-burst, then a fresh tenure gets the full 4 writes
    bus.wdata = 32'h00005000;
    cyc(4'b0010, 4'b0010);
    check("rb.g1", 32'(bus.gnt), 32'h2);
    cyc(4'b0010, 4'b0010);
    cyc(4'b0010, 4'b0010);
    check("rb.q", 32'(bus.q), 32'h50);
    #2 res = 1'b0;
    #1 chk_reset_vals("burst");
    @(negedge clk);
    res = 1'b1;
    cyc(4'b0010, 4'b0010);
    check("rb.regnt", 32'(bus.gnt), 32'h2);
    for (int i = 0; i < 3; i++) begin
      bus.wdata[15:8] = 8'h61 + 8'(i);
      cyc(4'b0010, 4'b0010);
      check("rb.hold.gnt", 32'(bus.gnt), 32'h2);
      check("rb.hold.ack", 32'(bus.ack), 32'h2);
    end
    bus.wdata[15:8] = 8'h64;
    cyc(4'b0011, 4'b0010);
    check("rb.4th.ack", 32'(bus.ack), 32'h2); check("rb.4th.q", 32'(bus.q), 32'h64);
    check("rb.release", 32'(bus.gnt), 32'h1);
    cyc(4'b0000, 4'b0000);
    check("rb.idle", 32'(bus.gnt), 32'h0);
    cyc(4'b0000, 4'b0000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
